// File: rtl/morse_rx_rate_controller_pkg.sv
// Package for the Morse receiver rate controller.
// Holds the controller state encoding and the candidate dot-period function
// used by the search. DOT_W_PKG is the dot-period width the function works on;
// the controller's DOT_W parameter must match it.
package morse_rx_ctrl_pkg;

    localparam int DOT_W_PKG = 16;
    localparam int CAND_W    = DOT_W_PKG + 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        TRY    = 3'd2,
        LOCKED = 3'd3,
        FAIL   = 3'd4
    } rx_ctrl_state_t;

    // Candidate k alternates around the nominal period: k=0 -> init,
    // k=1 -> +step, k=2 -> -step, k=3 -> +2*step, ... The result is
    // clamped to [1, 2^DOT_W-1] so the receiver never sees a zero period.
    function automatic logic [DOT_W_PKG-1:0] candidate_period(
        input logic [DOT_W_PKG-1:0] init,
        input logic [7:0]           k,
        input logic [DOT_W_PKG-1:0] step
    );
        logic [CAND_W-1:0]        m;
        logic signed [CAND_W-1:0] off;
        logic signed [CAND_W-1:0] sum;
        m   = CAND_W'((9'(k) + 9'd1) >> 1);
        off = $signed(m * {2'b00, step});
        if (!k[0]) begin
            off = -off;
        end
        sum = $signed({2'b00, init}) + off;
        if (sum < $signed(CAND_W'(1))) begin
            return DOT_W_PKG'(1);
        end else if (sum > $signed({2'b00, {DOT_W_PKG{1'b1}}})) begin
            return {DOT_W_PKG{1'b1}};
        end
        return DOT_W_PKG'(sum);
    endfunction

endpackage

// File: rtl/morse_rx_rate_controller_if.sv
// Decoded-character stream between the rate controller and its consumer.
//   char_o        FIFO head character
//   char_valid_o  FIFO not empty
//   char_ready_i  consumer accepts the head this cycle
// master: controller side; slave: consumer side.
interface morse_rx_rate_controller_if;
    logic [7:0] char_o;
    logic       char_valid_o;
    logic       char_ready_i;

    modport master (output char_o, output char_valid_o, input char_ready_i);
    modport slave  (input char_o, input char_valid_o, output char_ready_i);
endinterface

// File: rtl/morse_rx_rate_controller_fifo.sv
// morse_char_fifo: small synchronous FIFO for decoded characters.
//   clk_i, rst_i (async, active-low), flush_i (sync empty)
//   push_i/din_i   write side; a push while full is accepted only with a pop
//   pop_i/dout_o   read side; dout_o is the head, pop while empty is ignored
//   full_o/empty_o status
// Pointers carry one extra bit so full and empty are distinguishable.
module morse_char_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot being written.
    assign do_push = push_i & (~full_o | do_pop);
    assign dout_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= din_i;
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/morse_rx_rate_controller.sv
// morse_rx_rate_controller: tunes the dot period of a morse_char_receiver.
// Searches candidate periods around a nominal value until LOCK_CHARS good
// characters arrive in a row, re-tunes after ERR_LIMIT consecutive errors
// while locked, and buffers decoded characters in a FIFO.
// Ports:
//   clk_i, rst_i (async, active-low), enable_i (0 = idle + flush)
//   dot_period_init_i      nominal period, latched when leaving IDLE
//   rx_char_i, rx_char_valid_i, rx_unknown_i, rx_dot_period_error_i  receiver outputs
//   rx_dot_period_o        registered period to the receiver
//   char_if (master)       decoded-character stream to the consumer
//   locked_o, fail_o       state flags; overflow_o sticky FIFO drop flag
// Optional build macro MORSE_RX_RATE_STATS_EN adds retune_cnt_o and err_cnt_o
// (saturating counts of search restarts and bad events).
module morse_rx_rate_controller
    import morse_rx_ctrl_pkg::*;
#(
    parameter int DOT_W      = DOT_W_PKG,
    parameter int STEP       = 4,
    parameter int MAX_TRIES  = 9,
    parameter int LOCK_CHARS = 3,
    parameter int ERR_LIMIT  = 2,
    parameter int SETTLE_CYC = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic [DOT_W-1:0] dot_period_init_i,
    input  logic [7:0]       rx_char_i,
    input  logic             rx_char_valid_i,
    input  logic             rx_unknown_i,
    input  logic             rx_dot_period_error_i,
    output logic [DOT_W-1:0] rx_dot_period_o,
    morse_rx_rate_controller_if.master char_if,
    output logic             locked_o,
    output logic             fail_o,
    output logic             overflow_o
`ifdef MORSE_RX_RATE_STATS_EN
   ,output logic [15:0]      retune_cnt_o,
    output logic [15:0]      err_cnt_o
`endif
);
    localparam int KW = $clog2(MAX_TRIES + 1);
    localparam int GW = $clog2(LOCK_CHARS + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam logic [KW-1:0] K_LAST = KW'(MAX_TRIES - 1);
    localparam logic [GW-1:0] G_LAST = GW'(LOCK_CHARS - 1);
    localparam logic [EW-1:0] E_LAST = EW'(ERR_LIMIT - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYC - 1);

    rx_ctrl_state_t   state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [GW-1:0]    good_q, good_d;
    logic [EW-1:0]    lerr_q, lerr_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [DOT_W-1:0] init_q, init_src;
    logic             load, push, bad_seen, retune;
    logic             good_evt, bad_evt;
    logic             fifo_full, fifo_empty, pop;

    // A period error in the same cycle as a char makes the whole cycle bad.
    assign bad_evt  = rx_dot_period_error_i | (rx_char_valid_i & rx_unknown_i);
    assign good_evt = rx_char_valid_i & ~rx_unknown_i & ~rx_dot_period_error_i;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        good_d   = good_q;
        lerr_d   = lerr_q;
        settle_d = settle_q;
        load     = 1'b0;
        push     = 1'b0;
        bad_seen = 1'b0;
        retune   = 1'b0;
        if (!enable_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = SETTLE;
                    k_d      = '0;
                    settle_d = '0;
                    load     = 1'b1;
                end
                SETTLE: begin
                    if (settle_q == S_LAST) begin
                        state_d = TRY;
                        good_d  = '0;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                TRY: begin
                    if (bad_evt) begin
                        bad_seen = 1'b1;
                        k_d      = k_q + 1'b1;
                        if (k_q == K_LAST) begin
                            state_d = FAIL;
                        end else begin
                            state_d  = SETTLE;
                            settle_d = '0;
                            load     = 1'b1;
                        end
                    end else if (good_evt) begin
                        push = 1'b1;
                        if (good_q == G_LAST) begin
                            state_d = LOCKED;
                            lerr_d  = '0;
                        end else begin
                            good_d = good_q + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (bad_evt) begin
                        bad_seen = 1'b1;
                        if (lerr_q == E_LAST) begin
                            retune   = 1'b1;
                            state_d  = SETTLE;
                            k_d      = KW'(1);
                            settle_d = '0;
                            lerr_d   = '0;
                            load     = 1'b1;
                        end else begin
                            lerr_d = lerr_q + 1'b1;
                        end
                    end else if (good_evt) begin
                        push   = 1'b1;
                        lerr_d = '0;
                    end
                end
                FAIL: ;
                default: state_d = IDLE;
            endcase
        end
    end

    // The nominal period is taken straight from the input on the IDLE exit.
    assign init_src = (state_q == IDLE) ? dot_period_init_i : init_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q         <= IDLE;
            k_q             <= '0;
            good_q          <= '0;
            lerr_q          <= '0;
            settle_q        <= '0;
            init_q          <= '0;
            rx_dot_period_o <= '0;
            overflow_o      <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            good_q   <= good_d;
            lerr_q   <= lerr_d;
            settle_q <= settle_d;
            if (state_q == IDLE && enable_i) begin
                init_q <= dot_period_init_i;
            end
            if (load) begin
                rx_dot_period_o <= DOT_W'(candidate_period(DOT_W_PKG'(init_src), 8'(k_d),
                                                           DOT_W_PKG'(STEP)));
            end
            if (!enable_i) begin
                overflow_o <= 1'b0;
            end else if (push && fifo_full && !pop) begin
                overflow_o <= 1'b1;
            end
        end
    end

    assign locked_o = (state_q == LOCKED);
    assign fail_o   = (state_q == FAIL);

    assign pop                  = char_if.char_ready_i & ~fifo_empty;
    assign char_if.char_valid_o = ~fifo_empty;

    morse_char_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (~enable_i),
        .push_i  (push),
        .din_i   (rx_char_i),
        .pop_i   (pop),
        .dout_o  (char_if.char_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef MORSE_RX_RATE_STATS_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            retune_cnt_o <= '0;
            err_cnt_o    <= '0;
        end else if (!enable_i) begin
            retune_cnt_o <= '0;
            err_cnt_o    <= '0;
        end else begin
            if (retune && retune_cnt_o != 16'hFFFF) begin
                retune_cnt_o <= retune_cnt_o + 1'b1;
            end
            if (bad_seen && err_cnt_o != 16'hFFFF) begin
                err_cnt_o <= err_cnt_o + 1'b1;
            end
        end
    end
`else
    // Statistics disabled: the event strobes have no consumer.
    logic unused_stats;
    assign unused_stats = retune ^ bad_seen;
`endif

endmodule
